// File: rtl/rv32v_uop_sequencer.sv
// Vector micro-op sequencer: latches one decoded RVV instruction and issues it
// as NUM_LANES-wide element groups with per-group physical registers and lane masks.
module rv32v_uop_sequencer #(
   parameter int VLEN      = 128,
   parameter int NUM_LANES = 4,
   parameter int VL_W      = $clog2(VLEN) + 1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 flush_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [4:0]           in_vd_i,
   input  logic [4:0]           in_vs1_i,
   input  logic [4:0]           in_vs2_i,
   input  logic [VL_W-1:0]      in_vl_i,
   input  logic [1:0]           in_vsew_i,
   input  logic [2:0]           in_vlmul_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [4:0]           out_vd_o,
   output logic [4:0]           out_vs1_o,
   output logic [4:0]           out_vs2_o,
   output logic [VL_W-1:0]      out_eidx_o,
   output logic [NUM_LANES-1:0] out_lane_mask_o,
   output logic                 out_first_o,
   output logic                 out_last_o,
   output logic                 busy_o
);

   localparam int EPR_MAX      = VLEN / 8;
   localparam int LOG2_EPR_MAX = $clog2(EPR_MAX);
   localparam int SH_W         = $clog2(LOG2_EPR_MAX + 1);
   localparam int EW           = VL_W + 1;

   typedef enum logic [0:0] {
      IDLE,
      ISSUE
   } state_e;

   state_e           state_q, state_d;
   logic [VL_W-1:0]  vl_q, vl_d;
   logic [VL_W-1:0]  eidx_q, eidx_d;
   logic [4:0]       vd_q, vd_d;
   logic [4:0]       vs1_q, vs1_d;
   logic [4:0]       vs2_q, vs2_d;
   logic [SH_W-1:0]  shift_q, shift_d;

   logic [VL_W-1:0]  epr;
   logic [VL_W-1:0]  vlmax;
   logic [VL_W-1:0]  vlClamped;
   logic [SH_W-1:0]  shiftIn;
   logic [EW-1:0]    eidxNext;
   logic [VL_W-1:0]  regOffset;
   logic             issuing;
   logic             isLast;
   logic             accept;

   // Register-group geometry of the incoming instruction; vlmul=100 falls back to LMUL=1.
   always_comb begin
      epr = VL_W'(EPR_MAX) >> in_vsew_i;
      case (in_vlmul_i)
         3'b000, 3'b001, 3'b010, 3'b011: vlmax = epr << in_vlmul_i[1:0];
         3'b101:                         vlmax = epr >> 3;
         3'b110:                         vlmax = epr >> 2;
         3'b111:                         vlmax = epr >> 1;
         default:                        vlmax = epr;
      endcase
      vlClamped = (in_vl_i < vlmax) ? in_vl_i : vlmax;
      shiftIn   = SH_W'(LOG2_EPR_MAX) - SH_W'(in_vsew_i);
   end

   assign issuing   = (state_q == ISSUE);
   assign eidxNext  = {1'b0, eidx_q} + EW'(NUM_LANES);
   assign isLast    = (eidxNext >= {1'b0, vl_q});
   assign regOffset = eidx_q >> shift_q;

   assign in_ready_o = !flush_i && ((state_q == IDLE) || (issuing && out_ready_i && isLast));
   assign accept     = in_valid_i && in_ready_o;

   assign out_valid_o = issuing;
   assign busy_o      = issuing;
   assign out_eidx_o  = eidx_q;
   assign out_vd_o    = vd_q  + regOffset[4:0];
   assign out_vs1_o   = vs1_q + regOffset[4:0];
   assign out_vs2_o   = vs2_q + regOffset[4:0];
   assign out_first_o = issuing && (eidx_q == '0);
   assign out_last_o  = issuing && isLast;

   always_comb begin
      out_lane_mask_o = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         out_lane_mask_o[i] = issuing && (({1'b0, eidx_q} + EW'(i)) < {1'b0, vl_q});
      end
   end

   // Next-state logic; a fresh accept overrides whatever the case statement decided,
   // which covers both the idle start and the back-to-back handoff on the last group.
   always_comb begin
      state_d = state_q;
      vl_d    = vl_q;
      eidx_d  = eidx_q;
      vd_d    = vd_q;
      vs1_d   = vs1_q;
      vs2_d   = vs2_q;
      shift_d = shift_q;

      case (state_q)
         IDLE: begin
            state_d = IDLE;
         end
         ISSUE: begin
            if (flush_i) begin
               state_d = IDLE;
            end else if (out_ready_i) begin
               if (isLast) begin
                  state_d = IDLE;
               end else begin
                  eidx_d = eidxNext[VL_W-1:0];
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (accept) begin
         state_d = ISSUE;
         vl_d    = vlClamped;
         eidx_d  = '0;
         vd_d    = in_vd_i;
         vs1_d   = in_vs1_i;
         vs2_d   = in_vs2_i;
         shift_d = shiftIn;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         vl_q    <= '0;
         eidx_q  <= '0;
         vd_q    <= '0;
         vs1_q   <= '0;
         vs2_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         vl_q    <= vl_d;
         eidx_q  <= eidx_d;
         vd_q    <= vd_d;
         vs1_q   <= vs1_d;
         vs2_q   <= vs2_d;
         shift_q <= shift_d;
      end
   end

endmodule
